// File: rtl/mips_pipe_ctrl.sv
// Pipeline control and hazard unit: per-stage scoreboard of in-flight writes driving
// load-use stalls, operand forwarding selects, decode-redirect flushes and a stall counter.
module mips_pipe_ctrl #(
   parameter int NSTAGES    = 3,
   parameter int LOAD_STAGE = 2,
   parameter int REG_AW     = 5,
   parameter int SEL_W      = 2,
   parameter int CNT_W      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               hold,
   input  logic               d_valid,
   input  logic [REG_AW-1:0]  d_rs,
   input  logic [REG_AW-1:0]  d_rt,
   input  logic               d_rs_used,
   input  logic               d_rt_used,
   input  logic               d_wr_en,
   input  logic [REG_AW-1:0]  d_wr_addr,
   input  logic               d_is_load,
   input  logic               d_redirect,
   output logic               stall,
   output logic               issue,
   output logic               fd_flush,
   output logic [SEL_W-1:0]   fwd_rs_sel,
   output logic [SEL_W-1:0]   fwd_rt_sel,
   output logic [NSTAGES-1:0] stage_valid,
   output logic               wb_en,
   output logic [REG_AW-1:0]  wb_addr,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef struct packed {
      logic              v;
      logic              wr_en;
      logic [REG_AW-1:0] addr;
      logic              is_load;
   } entry_t;

   // Index i holds pipeline stage i+1 (0 = EX).
   entry_t            sb_q [NSTAGES];
   entry_t            sb_d [NSTAGES];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [NSTAGES-1:0] rs_hit, rt_hit, ld_early;
   logic [SEL_W-1:0]   rs_sel, rt_sel;
   logic               rs_wait, rt_wait;

   genvar gi;
   generate
      for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
         assign rs_hit[gi]      = sb_q[gi].v & sb_q[gi].wr_en & (sb_q[gi].addr == d_rs) & (d_rs != '0);
         assign rt_hit[gi]      = sb_q[gi].v & sb_q[gi].wr_en & (sb_q[gi].addr == d_rt) & (d_rt != '0);
         assign ld_early[gi]    = sb_q[gi].is_load & ((gi + 1) < LOAD_STAGE);
         assign stage_valid[gi] = sb_q[gi].v & sb_q[gi].wr_en;
      end
   endgenerate

   // Walk oldest to youngest so the youngest matching writer wins.
   always_comb begin
      rs_sel  = '0;
      rt_sel  = '0;
      rs_wait = 1'b0;
      rt_wait = 1'b0;
      for (int i = NSTAGES - 1; i >= 0; i--) begin
         if (d_rs_used && rs_hit[i]) begin
            rs_sel  = SEL_W'(i + 1);
            rs_wait = ld_early[i];
         end
         if (d_rt_used && rt_hit[i]) begin
            rt_sel  = SEL_W'(i + 1);
            rt_wait = ld_early[i];
         end
      end
   end

   assign fwd_rs_sel = rs_wait ? '0 : rs_sel;
   assign fwd_rt_sel = rt_wait ? '0 : rt_sel;
   assign stall      = d_valid & (rs_wait | rt_wait);
   assign issue      = d_valid & ~stall & ~hold;
   assign fd_flush   = issue & d_redirect;

   always_comb begin
      sb_d  = sb_q;
      cnt_d = cnt_q;
      if (!hold) begin
         sb_d[0].v       = issue;
         sb_d[0].wr_en   = d_wr_en;
         sb_d[0].addr    = d_wr_addr;
         sb_d[0].is_load = d_is_load;
         for (int i = 1; i < NSTAGES; i++) begin
            sb_d[i] = sb_q[i-1];
         end
         if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSTAGES; i++) begin
            sb_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         sb_q  <= sb_d;
         cnt_q <= cnt_d;
      end
   end

   assign wb_en     = sb_q[NSTAGES-1].v & sb_q[NSTAGES-1].wr_en & (sb_q[NSTAGES-1].addr != '0);
   assign wb_addr   = sb_q[NSTAGES-1].addr;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: NSTAGES=3, LOAD_STAGE=2, narrow stall counter so
// saturation is reachable quickly.
module tb_mips_pipe_ctrl;

   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          hold = 1'b0;
   logic          d_valid = 1'b0;
   logic [4:0]    d_rs = '0, d_rt = '0, d_wr_addr = '0;
   logic          d_rs_used = 1'b0, d_rt_used = 1'b0, d_wr_en = 1'b0;
   logic          d_is_load = 1'b0, d_redirect = 1'b0;
   logic          stall, issue, fd_flush, wb_en;
   logic [1:0]    fwd_rs_sel, fwd_rt_sel;
   logic [2:0]    stage_valid;
   logic [4:0]    wb_addr;
   logic [CW-1:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   mips_pipe_ctrl #(.NSTAGES(3), .LOAD_STAGE(2), .REG_AW(5), .SEL_W(2), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .hold(hold), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
      .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_is_load(d_is_load), .d_redirect(d_redirect),
      .stall(stall), .issue(issue), .fd_flush(fd_flush),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stage_valid(stage_valid),
      .wb_en(wb_en), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   // Apply one decode-cycle's inputs at the falling edge; outputs settle by +1.
   task automatic drive(input logic h, input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic we,
                        input logic [4:0] wa, input logic ld, input logic rd);
      @(negedge clock);
      hold = h; d_valid = v; d_rs = rs; d_rs_used = rsu; d_rt = rt; d_rt_used = rtu;
      d_wr_en = we; d_wr_addr = wa; d_is_load = ld; d_redirect = rd;
      #1;
      $display("txn t=%0t hold=%0b v=%0b rs=%0d/%0b rt=%0d/%0b wr=%0b:%0d ld=%0b rd=%0b -> stall=%0b issue=%0b",
               $time, h, v, rs, rsu, rt, rtu, we, wa, ld, rd, stall, issue);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL rst_issue got=%0h exp=1", issue); end
      total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL rst_fwd got=%0h/%0h exp=0/0", fwd_rs_sel, fwd_rt_sel); end
      total++; if (stage_valid !== 3'b000) begin bad++; $display("FAIL rst_stage_valid got=%0h exp=0", stage_valid); end
      total++; if (wb_en !== 1'b0 || wb_addr !== 5'd0) begin bad++; $display("FAIL rst_wb got=%0h:%0h exp=0:0", wb_en, wb_addr); end
      total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", stall_cnt); end
      @(negedge clock);
      reset = 1'b0; d_valid = 1'b0;
      idle(2);
   endtask

   task automatic test_forward();
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL fw_issue got=%0h exp=1", issue); end
      drive(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      total++; if (fwd_rs_sel !== 2'd1) begin bad++; $display("FAIL fw_sel1 got=%0h exp=1", fwd_rs_sel); end
      total++; if (stage_valid !== 3'b001) begin bad++; $display("FAIL fw_sv1 got=%0h exp=1", stage_valid); end
      drive(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      total++; if (fwd_rs_sel !== 2'd2) begin bad++; $display("FAIL fw_sel2 got=%0h exp=2", fwd_rs_sel); end
      total++; if (stage_valid !== 3'b010) begin bad++; $display("FAIL fw_sv2 got=%0h exp=2", stage_valid); end
      drive(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      total++; if (fwd_rs_sel !== 2'd3) begin bad++; $display("FAIL fw_sel3 got=%0h exp=3", fwd_rs_sel); end
      total++; if (wb_en !== 1'b1 || wb_addr !== 5'd3) begin bad++; $display("FAIL fw_wb got=%0h:%0h exp=1:3", wb_en, wb_addr); end
      drive(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL fw_sel0 got=%0h exp=0", fwd_rs_sel); end
      total++; if (stage_valid !== 3'b000 || wb_en !== 1'b0) begin bad++; $display("FAIL fw_gone got=%0h:%0h exp=0:0", stage_valid, wb_en); end
      idle(3);
   endtask

   task automatic test_load_use();
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      total++; if (issue !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL lu_lw got=%0h:%0h exp=1:0", issue, stall); end
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      total++; if (stall !== 1'b1 || issue !== 1'b0) begin bad++; $display("FAIL lu_stall got=%0h:%0h exp=1:0", stall, issue); end
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      total++; if (stall !== 1'b0 || issue !== 1'b1) begin bad++; $display("FAIL lu_release got=%0h:%0h exp=0:1", stall, issue); end
      total++; if (fwd_rt_sel !== 2'd2) begin bad++; $display("FAIL lu_sel got=%0h exp=2", fwd_rt_sel); end
      total++; if (stage_valid !== 3'b010) begin bad++; $display("FAIL lu_bubble got=%0h exp=2", stage_valid); end
      total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0h exp=1", stall_cnt); end
      idle(3);
      total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt_keep got=%0h exp=1", stall_cnt); end
   endtask

   task automatic test_youngest();
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      total++; if (fwd_rs_sel !== 2'd1) begin bad++; $display("FAIL yw_rs got=%0h exp=1", fwd_rs_sel); end
      total++; if (fwd_rt_sel !== 2'd2) begin bad++; $display("FAIL yw_rt got=%0h exp=2", fwd_rt_sel); end
      total++; if (wb_en !== 1'b1 || wb_addr !== 5'd4) begin bad++; $display("FAIL yw_wb got=%0h:%0h exp=1:4", wb_en, wb_addr); end
      drive(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL r0_fwd got=%0h/%0h exp=0/0", fwd_rs_sel, fwd_rt_sel); end
      total++; if (stall !== 1'b0 || issue !== 1'b1) begin bad++; $display("FAIL r0_stall got=%0h:%0h exp=0:1", stall, issue); end
      total++; if (wb_addr !== 5'd9) begin bad++; $display("FAIL yw_wb9 got=%0h exp=9", wb_addr); end
      idle(1);
      idle(1);
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL r0_wb got=%0h exp=0", wb_en); end
      idle(3);
   endtask

   task automatic test_redirect();
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      total++; if (fd_flush !== 1'b1) begin bad++; $display("FAIL rd_flush got=%0h exp=1", fd_flush); end
      idle(1);
      total++; if (fd_flush !== 1'b0) begin bad++; $display("FAIL rd_flush_off got=%0h exp=0", fd_flush); end
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      total++; if (stall !== 1'b1 || fd_flush !== 1'b0 || issue !== 1'b0) begin bad++; $display("FAIL rd_stalled got=%0h:%0h:%0h exp=1:0:0", stall, fd_flush, issue); end
      drive(1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      total++; if (fd_flush !== 1'b1 || fwd_rs_sel !== 2'd2) begin bad++; $display("FAIL rd_late got=%0h:%0h exp=1:2", fd_flush, fwd_rs_sel); end
      total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL rd_cnt got=%0h exp=2", stall_cnt); end
      idle(3);
   endtask

   task automatic test_hold();
      drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      total++; if (issue !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL hd_issue got=%0h:%0h exp=0:0", issue, stall); end
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      total++; if (stage_valid !== 3'b000) begin bad++; $display("FAIL hd_noentry got=%0h exp=0", stage_valid); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
         total++; if (stall !== 1'b1 || issue !== 1'b0) begin bad++; $display("FAIL hd_stall%0d got=%0h:%0h exp=1:0", i, stall, issue); end
         total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL hd_cnt%0d got=%0h exp=2", i, stall_cnt); end
         total++; if (stage_valid !== 3'b001) begin bad++; $display("FAIL hd_sb%0d got=%0h exp=1", i, stage_valid); end
      end
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      total++; if (stall !== 1'b1 || stall_cnt !== 4'd2) begin bad++; $display("FAIL hd_unhold got=%0h:%0h exp=1:2", stall, stall_cnt); end
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      total++; if (stall !== 1'b0 || fwd_rt_sel !== 2'd2 || stall_cnt !== 4'd3) begin bad++; $display("FAIL hd_release got=%0h:%0h:%0h exp=0:2:3", stall, fwd_rt_sel, stall_cnt); end
      idle(3);
   endtask

   // A load reading its own destination alternates issue/stall with constant inputs.
   task automatic test_saturate();
      int exp_cnt = 3;
      for (int i = 0; i < 2 * ((1 << CW) + 5); i++) begin
         drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
         total++; if (stall !== ((i % 2) == 1)) begin bad++; $display("FAIL sat_stall%0d got=%0h exp=%0h", i, stall, (i % 2) == 1); end
         total++; if (stall_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL sat_cnt%0d got=%0h exp=%0h", i, stall_cnt, exp_cnt); end
         if ((i % 2) == 1 && exp_cnt < (1 << CW) - 1) exp_cnt++;
      end
      total++; if (stall_cnt !== {CW{1'b1}}) begin bad++; $display("FAIL sat_final got=%0h exp=%0h", stall_cnt, {CW{1'b1}}); end
   endtask

   task automatic test_reset_mid_stall();
      idle(3);
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL mr_pre got=%0h exp=1", stall); end
      #1 reset = 1'b1;
      #1;
      total++; if (stall !== 1'b0 || issue !== 1'b1) begin bad++; $display("FAIL mr_stall got=%0h:%0h exp=0:1", stall, issue); end
      total++; if (stall_cnt !== 4'd0 || stage_valid !== 3'b000) begin bad++; $display("FAIL mr_clear got=%0h:%0h exp=0:0", stall_cnt, stage_valid); end
      @(negedge clock);
      reset = 1'b0; d_valid = 1'b0;
      idle(1);
      total++; if (stage_valid !== 3'b000) begin bad++; $display("FAIL mr_after got=%0h exp=0", stage_valid); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_youngest();
      test_redirect();
      test_hold();
      test_saturate();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
